datapath_sequencer: RTL and testbench

- Multi-cycle controller for the 4-bit processor datapath: 4x4 register file (two read ports, one write port), ALU (4-bit select) and shifter (3-bit select).
- Accepts one instruction word per valid/ready handshake and drives register addresses, write enable, ALU/shifter selects and the write-back source mux.
- Supports repeated shift passes, a flag register and a handshaked store output.
- Sits between the instruction source and the datapath.

---
 rtl/datapath_sequencer.sv | 168 ++++++++++++++++
 tb/tb_datapath_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: multi-cycle controller for the 4-bit register-file /
// ALU / shifter datapath. One instruction per valid/ready handshake; drives
// register addresses, write enable, function selects and write-back mux.
// Optional feature macro: SEQ_SKIP_EN (kind 11 becomes a flag-conditional
// SKIP of the next instruction; when undefined kind 11 is a NOP).
module datapath_sequencer #(
  parameter int IW = 18,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [AW-1:0] a1,
  output logic [AW-1:0] a2,
  output logic [AW-1:0] a3,
  output logic          we,
  output logic          wsel,
  output logic [3:0]    alu_sel,
  output logic [2:0]    shf_sel,
  input  logic [3:0]    alu_flags,
  output logic [3:0]    flags,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, EXEC, REPEAT, STORE} state_t;

  localparam logic [1:0] K_ALU   = 2'b00;
  localparam logic [1:0] K_LOAD  = 2'b01;
  localparam logic [1:0] K_STORE = 2'b10;
  localparam logic [1:0] K_NOP   = 2'b11;

  // Field map of the instruction word, msb first.
  typedef struct packed {
    logic [1:0]    kind;
    logic [AW-1:0] rd;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [3:0]    alu;
    logic [2:0]    shf;
    logic [1:0]    rep;
    logic          fwe;
  } instr_t;

  state_t     state;
  instr_t     ir;
  logic [1:0] cnt;
  logic [3:0] flags_q;
  logic       hs;
  logic       skip_act;   // current EXEC cycle is a suppressed instruction

  assign hs = instr_valid & instr_ready;

`ifdef SEQ_SKIP_EN
  logic skip_pend;

  assign skip_act = skip_pend;

  // Skip flag: set by a taken SKIP, consumed by the next instruction's EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skip_pend <= 1'b0;
    end else if (state == EXEC) begin
      if (skip_pend)
        skip_pend <= 1'b0;
      else if (ir.kind == K_NOP && flags_q[~ir.rb])
        skip_pend <= 1'b1;   // rb 00..11 selects z,s,v,c = flags[3..0]
    end
  end
`else
  assign skip_act = 1'b0;
`endif

  // Sequencer FSM: instruction latch, repeat counter and flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ir      <= '0;
      cnt     <= '0;
      flags_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            ir    <= instr;
            state <= EXEC;
          end
        end
        EXEC: begin
          state <= IDLE;
          if (!skip_act) begin
            case (ir.kind)
              K_ALU: begin
                if (ir.fwe) flags_q <= alu_flags;
                cnt <= ir.rep;
                if (ir.rep != 2'd0) state <= REPEAT;
              end
              K_STORE: state <= STORE;
              default: ;   // LOAD and NOP finish in one cycle
            endcase
          end
        end
        REPEAT: begin
          // Extra shift passes re-read rd; flags stay untouched here.
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) state <= IDLE;
        end
        STORE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath controls decoded from state and the latched instruction.
  always_comb begin
    a1        = '0;
    a2        = '0;
    a3        = '0;
    we        = 1'b0;
    wsel      = 1'b0;
    alu_sel   = 4'b0000;
    shf_sel   = 3'b000;
    out_valid = 1'b0;
    case (state)
      EXEC: begin
        if (!skip_act) begin
          case (ir.kind)
            K_ALU: begin
              a1      = ir.ra;
              a2      = ir.rb;
              alu_sel = ir.alu;
              shf_sel = ir.shf;
              a3      = ir.rd;
              we      = 1'b1;
            end
            K_LOAD: begin
              a3   = ir.rd;
              we   = 1'b1;
              wsel = 1'b1;
            end
            default: ;
          endcase
        end
      end
      REPEAT: begin
        a1      = ir.rd;   // feed back the value written on the previous edge
        shf_sel = ir.shf;
        a3      = ir.rd;
        we      = 1'b1;
      end
      STORE: begin
        a1        = ir.ra;   // transfer ra straight through to the output
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign flags       = flags_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: a small 4x4 register file / ALU / shifter
// model closes the loop around the sequencer; expected writes and stores are
// queued at issue time and popped when the DUT commits them.
module tb_datapath_sequencer;
  localparam int IW = 18;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic [AW-1:0] a1, a2, a3;
  logic          we, wsel;
  logic [3:0]    alu_sel;
  logic [2:0]    shf_sel;
  logic [3:0]    alu_flags;
  logic [3:0]    flags;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  always #5 clk = ~clk;

  datapath_sequencer #(.IW(IW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .a1(a1), .a2(a2), .a3(a3), .we(we),
    .wsel(wsel), .alu_sel(alu_sel), .shf_sel(shf_sel),
    .alu_flags(alu_flags), .flags(flags), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  // Datapath model: alu 0000 = transfer a, 0010 = add; shf 001 = shl1.
  logic [3:0] rf [4];
  logic [3:0] din, ra_v, rb_v, alu_y, shf_y, wdata;
  logic       c_o, v_o, init_done;

  always_comb begin
    ra_v  = rf[a1];
    rb_v  = rf[a2];
    alu_y = ra_v;
    c_o   = 1'b0;
    v_o   = 1'b0;
    if (alu_sel == 4'b0010) begin
      {c_o, alu_y} = {1'b0, ra_v} + {1'b0, rb_v};
      v_o = (ra_v[3] == rb_v[3]) && (alu_y[3] != ra_v[3]);
    end
    alu_flags = {alu_y == 4'd0, alu_y[3], v_o, c_o};
    shf_y     = (shf_sel == 3'b001) ? {alu_y[2:0], 1'b0} : alu_y;
    wdata     = wsel ? din : shf_y;
  end

  // Register file model: cleared once at start, not by sequencer reset.
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 4; i++) rf[i] <= 4'd0;
    end else if (we) begin
      rf[a3] <= wdata;
    end
  end

  typedef struct { logic [1:0] a; logic [3:0] d; } rec_t;
  rec_t wq[$];
  rec_t sq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every committed write must match the next queued one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && we === 1'b1) begin
      chk("write_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        rec_t r;
        r = wq.pop_front();
        chk("write_addr", 32'(a3), 32'(r.a));
        chk("write_data", 32'(wdata), 32'(r.d));
      end
    end
  end

  function automatic logic [17:0] mk(input logic [1:0] kind, input logic [1:0] rd,
      input logic [1:0] ra, input logic [1:0] rb, input logic [3:0] alu,
      input logic [2:0] shf, input logic [1:0] rep, input logic fwe);
    return {kind, rd, ra, rb, alu, shf, rep, fwe};
  endfunction

  // Handshake one word, then count busy cycles and out_valid cycles;
  // out_ready is held low for the first 'hold' out_valid cycles.
  task automatic issue(input logic [17:0] w, input logic [3:0] d, input int hold,
                       output int bc, output int ovc);
    int guard;
    din = d;
    instr = w;
    instr_valid = 1'b1;
    guard = 0;
    while (instr_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    bc = 0;
    ovc = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) break;
      bc++;
      chk("ready_low_while_busy", 32'(instr_ready), 32'd0);
      if (out_valid === 1'b1) begin
        ovc++;
        chk("store_no_write", 32'(we), 32'd0);
        if (ovc > hold) begin
          out_ready = 1'b1;
          chk("store_expected", 32'(sq.size() != 0), 32'd1);
          if (sq.size() != 0) begin
            rec_t r;
            r = sq.pop_front();
            chk("store_a1", 32'(a1), 32'(r.a));
            chk("store_data", 32'(shf_y), 32'(r.d));
          end
        end
      end
    end
    chk("busy_drops", 32'(busy), 32'd0);
    out_ready = 1'b0;
  endtask

  int bc, ovc;

  initial begin
    rst_n = 1'b0;
    instr = '0;
    instr_valid = 1'b0;
    out_ready = 1'b0;
    din = '0;
    init_done = 1'b0;
    repeat (2) @(negedge clk);
    init_done = 1'b1;
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // LOAD r1=5, LOAD r2=3: one busy cycle each.
    wq.push_back('{2'd1, 4'h5});
    issue(mk(2'b01, 2'd1, 2'd0, 2'd0, 4'd0, 3'd0, 2'd0, 1'b0), 4'h5, 0, bc, ovc);
    chk("load1_busy", 32'(bc), 32'd1);
    wq.push_back('{2'd2, 4'h3});
    issue(mk(2'b01, 2'd2, 2'd0, 2'd0, 4'd0, 3'd0, 2'd0, 1'b0), 4'h3, 0, bc, ovc);
    chk("load2_busy", 32'(bc), 32'd1);

    // r3 = r1 + r2 = 8 with flag write: {z,s,v,c} = 0110.
    wq.push_back('{2'd3, 4'h8});
    issue(mk(2'b00, 2'd3, 2'd1, 2'd2, 4'b0010, 3'b000, 2'd0, 1'b1), 4'h0, 0, bc, ovc);
    chk("add_busy", 32'(bc), 32'd1);
    chk("add_flags", 32'(flags), 32'b0110);
    chk("add_r3", 32'(rf[3]), 32'h8);

    // r1 shifted left three times (EXEC + 2 repeats): 1010, 0100, 1000.
    wq.push_back('{2'd1, 4'hA});
    wq.push_back('{2'd1, 4'h4});
    wq.push_back('{2'd1, 4'h8});
    issue(mk(2'b00, 2'd1, 2'd1, 2'd0, 4'b0000, 3'b001, 2'd2, 1'b0), 4'h0, 0, bc, ovc);
    chk("rep_busy", 32'(bc), 32'd3);
    chk("rep_flags_kept", 32'(flags), 32'b0110);
    chk("rep_r1", 32'(rf[1]), 32'h8);

    // STORE r3 with out_ready held low for 3 cycles.
    sq.push_back('{2'd3, 4'h8});
    issue(mk(2'b10, 2'd0, 2'd3, 2'd0, 4'd0, 3'd0, 2'd0, 1'b0), 4'h0, 3, bc, ovc);
    chk("store_valid_cycles", 32'(ovc), 32'd4);
    chk("store_busy", 32'(bc), 32'd5);
    chk("store_then_idle", 32'(instr_ready), 32'd1);

    // Reset after the first pass of a rep=2 shift has committed.
    wq.push_back('{2'd1, 4'h5});
    issue(mk(2'b01, 2'd1, 2'd0, 2'd0, 4'd0, 3'd0, 2'd0, 1'b0), 4'h5, 0, bc, ovc);
    wq.push_back('{2'd1, 4'hA});
    instr = mk(2'b00, 2'd1, 2'd1, 2'd0, 4'b0000, 3'b001, 2'd2, 1'b0);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);            // EXEC pass commits 1010 here
    #1 chk("rep_pass_we", 32'(we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_flags", 32'(flags), 32'd0);
    chk("mid_rst_ready", 32'(instr_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_r1", 32'(rf[1]), 32'hA);
    chk("mid_rst_drained", 32'(wq.size()), 32'd0);

    // Skip: set v via 5+3, SKIP on v, then LOAD r0=F.
    wq.push_back('{2'd1, 4'h5});
    issue(mk(2'b01, 2'd1, 2'd0, 2'd0, 4'd0, 3'd0, 2'd0, 1'b0), 4'h5, 0, bc, ovc);
    wq.push_back('{2'd3, 4'h8});
    issue(mk(2'b00, 2'd3, 2'd1, 2'd2, 4'b0010, 3'b000, 2'd0, 1'b1), 4'h0, 0, bc, ovc);
    chk("skip_setup_flags", 32'(flags), 32'b0110);
    issue(mk(2'b11, 2'd0, 2'd0, 2'd2, 4'd0, 3'd0, 2'd0, 1'b0), 4'h0, 0, bc, ovc);
    chk("skip_busy", 32'(bc), 32'd1);
`ifndef SEQ_SKIP_EN
    wq.push_back('{2'd0, 4'hF});
`endif
    issue(mk(2'b01, 2'd0, 2'd0, 2'd0, 4'd0, 3'd0, 2'd0, 1'b0), 4'hF, 0, bc, ovc);
    chk("skipped_load_busy", 32'(bc), 32'd1);
`ifdef SEQ_SKIP_EN
    chk("skipped_load_r0", 32'(rf[0]), 32'h0);
`else
    chk("nop_load_r0", 32'(rf[0]), 32'hF);
`endif
    // Skip state is consumed: the following LOAD writes normally.
    wq.push_back('{2'd0, 4'hA});
    issue(mk(2'b01, 2'd0, 2'd0, 2'd0, 4'd0, 3'd0, 2'd0, 1'b0), 4'hA, 0, bc, ovc);
    chk("after_skip_r0", 32'(rf[0]), 32'hA);
    // SKIP on c (clear) never suppresses the next instruction.
    issue(mk(2'b11, 2'd0, 2'd0, 2'd3, 4'd0, 3'd0, 2'd0, 1'b0), 4'h0, 0, bc, ovc);
    wq.push_back('{2'd2, 4'h7});
    issue(mk(2'b01, 2'd2, 2'd0, 2'd0, 4'd0, 3'd0, 2'd0, 1'b0), 4'h7, 0, bc, ovc);
    chk("untaken_skip_r2", 32'(rf[2]), 32'h7);

    chk("writes_drained", 32'(wq.size()), 32'd0);
    chk("stores_drained", 32'(sq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
